// File: rtl/mac_rx_fcs_check_pkg.sv
// Shared definitions for the receive-side FCS checker: CRC constants,
// length limits, FSM encoding and a bit-reversal helper.
package mac_rx_fcs_check_pkg;

    localparam logic [31:0] CRC_POLY          = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_SEED          = 32'hFFFF_FFFF;
    localparam int          MAX_WORDS_DEFAULT = 759;
    localparam int          LEN_W             = 11;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } rx_state_t;

    // Reverse the bit order of a 32-bit word (bit 0 <-> bit 31).
    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_rx_crc_step.sv
// Combinational Ethernet CRC-32 next-state function, 16 data bits per step.
// Data bit 0 enters the register first; the register shifts towards bit 31.
module mac_rx_crc_step
    import mac_rx_fcs_check_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [15:0] data,
    output logic [31:0] crc_out
);

    logic [31:0] acc;

    // Unrolled serial LFSR: one polynomial reduction per data bit.
    always_comb begin
        acc = crc_in;
        for (int i = 0; i < 16; i++) begin
            if (acc[31] ^ data[i]) begin
                acc = {acc[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                acc = {acc[30:0], 1'b0};
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/mac_rx_fcs_check.sv
// Receive FCS checker: runs CRC-32 over a 16-bit word stream, holds the
// last two words back so the FCS never enters the CRC, and issues a
// registered one-cycle verdict with length/error flags and statistics.
module mac_rx_fcs_check
    import mac_rx_fcs_check_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      rx_dat,
    input  logic             rx_dv,
    input  logic             rx_sof,
    input  logic             rx_eof,
    output logic             fcs_valid,
    output logic             fcs_ok,
    output logic             err_runt,
    output logic             err_long,
    output logic             err_abort,
    output logic [10:0]      frm_len,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
    localparam logic [LEN_W-1:0] LEN_SAT = '1;

    rx_state_t         state;
    logic [31:0]       lfsr;
    logic [15:0]       d1;
    logic [15:0]       d2;
    logic [LEN_W-1:0]  count;

    logic [31:0]       lfsr_step;
    logic [31:0]       lfsr_next;
    logic [31:0]       exp_fcs;
    logic [LEN_W-1:0]  len_now;

    logic              verdict;
    logic              v_ok;
    logic              v_runt;
    logic              v_long;
    logic              v_abort;
    logic [LEN_W-1:0]  v_len;

    mac_rx_crc_step u_crc_step (
        .crc_in  (lfsr),
        .data    (d2),
        .crc_out (lfsr_step)
    );

    // Next CRC state, expected FCS and the saturating length including this word.
    always_comb begin
        lfsr_next = (count >= LEN_W'(2)) ? lfsr_step : lfsr;
        exp_fcs   = ~bit_rev32(lfsr_next);
        len_now   = (count == LEN_SAT) ? count : count + LEN_W'(1);
    end

    // Verdict decode. An abort takes priority: a new sof+eof word arriving
    // mid-frame ends the old frame and the 1-word newcomer is dropped.
    always_comb begin
        verdict = 1'b0;
        v_ok    = 1'b0;
        v_runt  = 1'b0;
        v_long  = 1'b0;
        v_abort = 1'b0;
        v_len   = '0;
        if (rx_dv && rx_sof && (state == FRAME)) begin
            verdict = 1'b1;
            v_abort = 1'b1;
            v_len   = count;
            v_runt  = (count < LEN_W'(3));
            v_long  = (count > MAX_LEN);
        end else if (rx_dv && rx_sof && rx_eof) begin
            verdict = 1'b1;
            v_runt  = 1'b1;
            v_len   = LEN_W'(1);
        end else if (rx_dv && rx_eof && (state == FRAME)) begin
            verdict = 1'b1;
            v_len   = len_now;
            v_runt  = (len_now < LEN_W'(3));
            v_long  = (len_now > MAX_LEN);
            v_ok    = (d1 == exp_fcs[31:16]) && (rx_dat == exp_fcs[15:0])
                      && !v_runt && !v_long;
        end
    end

    // FSM, delay line, CRC register, registered verdict and statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= CRC_SEED;
            d1        <= '0;
            d2        <= '0;
            count     <= '0;
            fcs_valid <= 1'b0;
            fcs_ok    <= 1'b0;
            err_runt  <= 1'b0;
            err_long  <= 1'b0;
            err_abort <= 1'b0;
            frm_len   <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            fcs_valid <= verdict;
            if (verdict) begin
                fcs_ok    <= v_ok;
                err_runt  <= v_runt;
                err_long  <= v_long;
                err_abort <= v_abort;
                frm_len   <= v_len;
                if (v_ok) begin
                    if (good_cnt != '1) good_cnt <= good_cnt + CNT_W'(1);
                end else begin
                    if (bad_cnt != '1) bad_cnt <= bad_cnt + CNT_W'(1);
                end
            end
            if (rx_dv) begin
                if (rx_sof) begin
                    lfsr  <= CRC_SEED;
                    d1    <= rx_dat;
                    d2    <= '0;
                    count <= LEN_W'(1);
                    state <= (rx_eof || (state == FRAME && rx_eof)) ? IDLE : FRAME;
                end else if (state == FRAME) begin
                    lfsr  <= lfsr_next;
                    d2    <= d1;
                    d1    <= rx_dat;
                    count <= len_now;
                    if (rx_eof) state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_rx_fcs_check.sv
// Directed bench for mac_rx_fcs_check. The FCS reference uses the
// reflected CRC-32 form (0xEDB88320, right shift), independent of the RTL.
module tb_mac_rx_fcs_check;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rx_dat = '0;
    logic        rx_dv = 1'b0;
    logic        rx_sof = 1'b0;
    logic        rx_eof = 1'b0;
    logic        fcs_valid, fcs_ok, err_runt, err_long, err_abort;
    logic [10:0] frm_len;
    logic [2:0]  good_cnt, bad_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    logic [2:0] exp_good = '0;
    logic [2:0] exp_bad  = '0;

    logic [15:0] fb [0:799];
    int          fn;

    mac_rx_fcs_check #(.MAX_WORDS(759), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_dat    (rx_dat),
        .rx_dv     (rx_dv),
        .rx_sof    (rx_sof),
        .rx_eof    (rx_eof),
        .fcs_valid (fcs_valid),
        .fcs_ok    (fcs_ok),
        .err_runt  (err_runt),
        .err_long  (err_long),
        .err_abort (err_abort),
        .frm_len   (frm_len),
        .good_cnt  (good_cnt),
        .bad_cnt   (bad_cnt)
    );

    always #5 clk = ~clk;

    // Count verdict pulses, sampled away from the rising edge.
    always @(negedge clk) begin
        if (fcs_valid === 1'b1) pulses++;
    end

    // Reference FCS over fb[0..n-1] as transmitted: word {fcs[31:16]}, then {fcs[15:0]}.
    function automatic logic [31:0] model_fcs(input int n);
        logic [31:0] r;
        logic        f;
        r = 32'hFFFF_FFFF;
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 16; b++) begin
                f = r[0] ^ fb[w][b];
                r = r >> 1;
                if (f) r = r ^ 32'hEDB8_8320;
            end
        end
        return ~r;
    endfunction

    task automatic drive(input logic [15:0] dat, input logic dv, input logic sof, input logic eof);
        @(negedge clk);
        rx_dat = dat;
        rx_dv  = dv;
        rx_sof = sof;
        rx_eof = eof;
    endtask

    // Build fb with ndata words (value base+i) followed by the correct FCS.
    task automatic build_frame(input int ndata, input logic [15:0] base);
        logic [31:0] f;
        for (int i = 0; i < ndata; i++) fb[i] = base + 16'(i);
        f = model_fcs(ndata);
        fb[ndata]     = f[31:16];
        fb[ndata + 1] = f[15:0];
        fn = ndata + 2;
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < fn; i++) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(0, 3)) drive(16'($urandom), 1'b0, 1'b0, 1'b0);
            end
            drive(fb[i], 1'b1, (i == 0), (i == fn - 1));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) drive(16'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (fcs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", fcs_valid); end
        n_checks++; if ({fcs_ok, err_runt, err_long, err_abort} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 0000", {fcs_ok, err_runt, err_long, err_abort}); end
        n_checks++; if (frm_len !== 11'd0) begin n_fail++; $display("[TB] FAIL reset_len: got %0d want 0", frm_len); end
        n_checks++; if ({good_cnt, bad_cnt} !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d/%0d want 0/0", good_cnt, bad_cnt); end
        rst_n = 1'b1;
        drive(16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_good_frame();
        build_frame(64, 16'h0001);
        send_frame(1'b0);
        n_checks++; if (fcs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL good_early: got %b want 0", fcs_valid); end
        drive(16'h0, 1'b0, 1'b0, 1'b0);
        exp_good++;
        n_checks++; if (fcs_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL good_valid: got %b want 1", fcs_valid); end
        n_checks++; if (fcs_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL good_ok: got %b want 1", fcs_ok); end
        n_checks++; if (frm_len !== 11'd66) begin n_fail++; $display("[TB] FAIL good_len: got %0d want 66", frm_len); end
        n_checks++; if ({err_runt, err_long, err_abort} !== 3'b0) begin n_fail++; $display("[TB] FAIL good_err: got %b want 000", {err_runt, err_long, err_abort}); end
        n_checks++; if (good_cnt !== exp_good) begin n_fail++; $display("[TB] FAIL good_cnt: got %0d want %0d", good_cnt, exp_good); end
        drive(16'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (fcs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL good_pulse: got %b want 0", fcs_valid); end
        n_checks++; if (fcs_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL good_hold: got %b want 1", fcs_ok); end
    endtask

    task automatic test_bad_crc();
        build_frame(64, 16'h0001);
        fb[9] = fb[9] ^ 16'h0020;
        send_frame(1'b0);
        drive(16'h0, 1'b0, 1'b0, 1'b0);
        exp_bad++;
        n_checks++; if (fcs_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_valid: got %b want 1", fcs_valid); end
        n_checks++; if (fcs_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL bad_ok: got %b want 0", fcs_ok); end
        n_checks++; if (bad_cnt !== exp_bad) begin n_fail++; $display("[TB] FAIL bad_cnt: got %0d want %0d", bad_cnt, exp_bad); end
        n_checks++; if (good_cnt !== exp_good) begin n_fail++; $display("[TB] FAIL bad_goodcnt: got %0d want %0d", good_cnt, exp_good); end
        drive(16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        build_frame(64, 16'h0001);
        send_frame(1'b1);
        drive(16'h0, 1'b0, 1'b0, 1'b0);
        exp_good++;
        n_checks++; if (fcs_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_valid: got %b want 1", fcs_valid); end
        n_checks++; if (fcs_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_ok: got %b want 1", fcs_ok); end
        n_checks++; if (frm_len !== 11'd66) begin n_fail++; $display("[TB] FAIL gap_len: got %0d want 66", frm_len); end
        n_checks++; if (good_cnt !== exp_good) begin n_fail++; $display("[TB] FAIL gap_cnt: got %0d want %0d", good_cnt, exp_good); end
        drive(16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_runt();
        drive(16'h1111, 1'b1, 1'b1, 1'b0);
        drive(16'h2222, 1'b1, 1'b0, 1'b1);
        drive(16'h0, 1'b0, 1'b0, 1'b0);
        exp_bad++;
        n_checks++; if ({fcs_valid, err_runt, fcs_ok} !== 3'b110) begin n_fail++; $display("[TB] FAIL runt2_flags: got %b want 110", {fcs_valid, err_runt, fcs_ok}); end
        n_checks++; if (frm_len !== 11'd2) begin n_fail++; $display("[TB] FAIL runt2_len: got %0d want 2", frm_len); end
        drive(16'h3333, 1'b1, 1'b1, 1'b1);
        drive(16'h0, 1'b0, 1'b0, 1'b0);
        exp_bad++;
        n_checks++; if ({fcs_valid, err_runt, fcs_ok} !== 3'b110) begin n_fail++; $display("[TB] FAIL runt1_flags: got %b want 110", {fcs_valid, err_runt, fcs_ok}); end
        n_checks++; if (frm_len !== 11'd1) begin n_fail++; $display("[TB] FAIL runt1_len: got %0d want 1", frm_len); end
        n_checks++; if (bad_cnt !== exp_bad) begin n_fail++; $display("[TB] FAIL runt_cnt: got %0d want %0d", bad_cnt, exp_bad); end
        drive(16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_long();
        build_frame(758, 16'h0100);
        send_frame(1'b0);
        drive(16'h0, 1'b0, 1'b0, 1'b0);
        exp_bad++;
        n_checks++; if ({fcs_valid, err_long, fcs_ok} !== 3'b110) begin n_fail++; $display("[TB] FAIL long_flags: got %b want 110", {fcs_valid, err_long, fcs_ok}); end
        n_checks++; if (frm_len !== 11'd760) begin n_fail++; $display("[TB] FAIL long_len: got %0d want 760", frm_len); end
        n_checks++; if (bad_cnt !== exp_bad) begin n_fail++; $display("[TB] FAIL long_cnt: got %0d want %0d", bad_cnt, exp_bad); end
        drive(16'h0, 1'b0, 1'b0, 1'b0);
        // Exactly MAX_WORDS is still legal.
        build_frame(757, 16'h0200);
        send_frame(1'b0);
        drive(16'h0, 1'b0, 1'b0, 1'b0);
        exp_good++;
        n_checks++; if ({fcs_valid, err_long, fcs_ok} !== 3'b101) begin n_fail++; $display("[TB] FAIL max_flags: got %b want 101", {fcs_valid, err_long, fcs_ok}); end
        n_checks++; if (frm_len !== 11'd759) begin n_fail++; $display("[TB] FAIL max_len: got %0d want 759", frm_len); end
        drive(16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_eof_idle();
        int p0;
        p0 = pulses;
        drive(16'h5555, 1'b1, 1'b0, 1'b1);
        repeat (3) drive(16'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (pulses !== p0) begin n_fail++; $display("[TB] FAIL idle_eof_pulse: got %0d want %0d", pulses, p0); end
        n_checks++; if ({good_cnt, bad_cnt} !== {exp_good, exp_bad}) begin n_fail++; $display("[TB] FAIL idle_eof_cnt: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 19; i++) drive(16'(i + 1), 1'b1, (i == 0), 1'b0);
        build_frame(8, 16'hA000);
        drive(fb[0], 1'b1, 1'b1, 1'b0);
        drive(fb[1], 1'b1, 1'b0, 1'b0);
        exp_bad++;
        n_checks++; if ({fcs_valid, err_abort, fcs_ok} !== 3'b110) begin n_fail++; $display("[TB] FAIL abort_flags: got %b want 110", {fcs_valid, err_abort, fcs_ok}); end
        n_checks++; if (frm_len !== 11'd19) begin n_fail++; $display("[TB] FAIL abort_len: got %0d want 19", frm_len); end
        for (int i = 2; i < fn; i++) drive(fb[i], 1'b1, 1'b0, (i == fn - 1));
        drive(16'h0, 1'b0, 1'b0, 1'b0);
        exp_good++;
        n_checks++; if ({fcs_valid, fcs_ok, err_abort} !== 3'b110) begin n_fail++; $display("[TB] FAIL abort_next: got %b want 110", {fcs_valid, fcs_ok, err_abort}); end
        n_checks++; if (frm_len !== 11'd10) begin n_fail++; $display("[TB] FAIL abort_next_len: got %0d want 10", frm_len); end
        n_checks++; if ({good_cnt, bad_cnt} !== {exp_good, exp_bad}) begin n_fail++; $display("[TB] FAIL abort_cnt: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); end
        drive(16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        build_frame(64, 16'h0001);
        for (int i = 0; i < 29; i++) drive(fb[i], 1'b1, (i == 0), 1'b0);
        @(negedge clk);
        rx_dat = fb[29];
        rst_n  = 1'b0;
        drive(16'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        exp_good = '0;
        exp_bad  = '0;
        pulses   = 0;
        send_frame(1'b0);
        repeat (4) drive(16'h0, 1'b0, 1'b0, 1'b0);
        exp_good++;
        n_checks++; if (pulses !== 1) begin n_fail++; $display("[TB] FAIL rstmid_pulses: got %0d want 1", pulses); end
        n_checks++; if (fcs_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_ok: got %b want 1", fcs_ok); end
        n_checks++; if ({good_cnt, bad_cnt} !== {exp_good, exp_bad}) begin n_fail++; $display("[TB] FAIL rstmid_cnt: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 9; k++) begin
            drive(16'h7777, 1'b1, 1'b1, 1'b1);
            drive(16'h0, 1'b0, 1'b0, 1'b0);
            if (exp_bad != 3'd7) exp_bad++;
        end
        n_checks++; if (bad_cnt !== 3'd7) begin n_fail++; $display("[TB] FAIL sat_bad: got %0d want 7", bad_cnt); end
        n_checks++; if (good_cnt !== exp_good) begin n_fail++; $display("[TB] FAIL sat_good: got %0d want %0d", good_cnt, exp_good); end
        for (int k = 0; k < 8; k++) begin
            build_frame(4, 16'(16'h0C00 + k * 16));
            send_frame(1'b0);
            drive(16'h0, 1'b0, 1'b0, 1'b0);
            if (exp_good != 3'd7) exp_good++;
        end
        n_checks++; if (good_cnt !== exp_good) begin n_fail++; $display("[TB] FAIL sat_good2: got %0d want %0d", good_cnt, exp_good); end
        n_checks++; if (bad_cnt !== exp_bad) begin n_fail++; $display("[TB] FAIL sat_bad2: got %0d want %0d", bad_cnt, exp_bad); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_gaps();
        test_runt();
        test_long();
        test_eof_idle();
        test_abort();
        test_reset_mid_frame();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
